// File: rtl/minirisc_ctrl_if.sv
// Control bundle between the miniRISC sequencer and the datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface minirisc_ctrl_if;
  logic [5:0] opcode;
  logic [4:0] funct;
  logic       mem_ready;

  logic       RegWrite;
  logic       ImmSel;
  logic       ALUSrc;
  logic       CompEnbl;
  logic       ShiftAmntSel;
  logic       ShiftEnbl;
  logic       ShortBr;
  logic       LongBr;
  logic       MemRead;
  logic       MemWrite;
  logic       BranchReg;
  logic [1:0] ALUOp;
  logic [1:0] RegDst;
  logic [1:0] ShiftType;
  logic [1:0] BranchType;
  logic [1:0] JumpType;
  logic [1:0] MemToReg;

  logic       ir_en;
  logic       pc_en;
  logic [2:0] state;
  logic       illegal;
  logic       mem_err;
  logic       halted;

  modport master (
    input  opcode, funct, mem_ready,
    output RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
           ShortBr, LongBr, MemRead, MemWrite, BranchReg,
           ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
           ir_en, pc_en, state, illegal, mem_err, halted
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
           ShortBr, LongBr, MemRead, MemWrite, BranchReg,
           ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
           ir_en, pc_en, state, illegal, mem_err, halted
  );
endinterface

// File: rtl/minirisc_control_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the KGP miniRISC datapath.
// Decodes opcode/funct in ID, holds the control bundle until the instruction retires.
module minirisc_control_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic      clk,
  input logic      rst,
  minirisc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef struct packed {
    logic       immSel;
    logic       aluSrc;
    logic       compEnbl;
    logic       shiftAmntSel;
    logic       shiftEnbl;
    logic       shortBr;
    logic       longBr;
    logic       memRead;
    logic       memWrite;
    logic       branchReg;
    logic [1:0] aluOp;
    logic [1:0] regDst;
    logic [1:0] shiftType;
    logic [1:0] branchType;
    logic [1:0] jumpType;
    logic [1:0] memToReg;
  } ctrl_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       mem_err_q, mem_err_d;

  ctrl_t      decCtrl;
  logic       decIllegal;
  logic       decHalt;
  logic       pcEn;
  logic       isMemOp;
  logic       isBranch;

  always_comb begin
    decCtrl    = '0;
    decIllegal = 1'b0;
    decHalt    = 1'b0;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          5'd0: decCtrl.aluOp = 2'b01;
          5'd1: begin
            decCtrl.aluOp    = 2'b01;
            decCtrl.compEnbl = 1'b1;
          end
          5'd2: decCtrl.aluOp = 2'b10;
          5'd3: decCtrl.aluOp = 2'b11;
          5'd4: decCtrl.shiftEnbl = 1'b1;
          5'd5: begin
            decCtrl.shiftEnbl = 1'b1;
            decCtrl.shiftType = 2'b01;
          end
          5'd6: begin
            decCtrl.shiftEnbl    = 1'b1;
            decCtrl.shiftAmntSel = 1'b1;
          end
          5'd7: begin
            decCtrl.shiftEnbl    = 1'b1;
            decCtrl.shiftType    = 2'b01;
            decCtrl.shiftAmntSel = 1'b1;
          end
          5'd8: begin
            decCtrl.shiftEnbl = 1'b1;
            decCtrl.shiftType = 2'b10;
          end
          5'd9: begin
            decCtrl.shiftEnbl    = 1'b1;
            decCtrl.shiftType    = 2'b10;
            decCtrl.shiftAmntSel = 1'b1;
          end
          default: decIllegal = 1'b1;
        endcase
      end
      6'b000001: begin
        decCtrl.aluSrc = 1'b1;
        decCtrl.aluOp  = 2'b01;
      end
      6'b000010: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.aluOp    = 2'b01;
        decCtrl.compEnbl = 1'b1;
      end
      6'b000011: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.immSel   = 1'b1;
        decCtrl.aluOp    = 2'b01;
        decCtrl.memRead  = 1'b1;
        decCtrl.memToReg = 2'b01;
      end
      6'b000100: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.immSel   = 1'b1;
        decCtrl.aluOp    = 2'b01;
        decCtrl.memWrite = 1'b1;
      end
      6'b000101: decCtrl.branchReg = 1'b1;
      6'b001000, 6'b001001, 6'b001010: begin
        decCtrl.shortBr    = 1'b1;
        decCtrl.branchType = bus.opcode[1:0];
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        decCtrl.longBr   = 1'b1;
        decCtrl.jumpType = bus.opcode[1:0];
        // bl writes the link address: PC+4 into the link register
        if (bus.opcode[1:0] == 2'b01) begin
          decCtrl.regDst   = 2'b10;
          decCtrl.memToReg = 2'b10;
        end
      end
      6'b111111: decHalt = 1'b1;
      default:   decIllegal = 1'b1;
    endcase
    if (decIllegal) begin
      decCtrl = '0;
    end
  end

  assign isMemOp  = ctrl_q.memRead | ctrl_q.memWrite;
  assign isBranch = ctrl_q.shortBr | ctrl_q.branchReg |
                    (ctrl_q.longBr & (ctrl_q.jumpType != 2'b01));

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    pcEn      = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (decHalt) begin
          state_d = S_HALT;
        end else if (decIllegal) begin
          illegal_d = 1'b1;
          pcEn      = 1'b1;
          state_d   = S_IF;
        end else begin
          ctrl_d  = decCtrl;
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (isMemOp) begin
          state_d = S_MEM;
        end else if (isBranch) begin
          pcEn    = 1'b1;
          ctrl_d  = '0;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A ready on the last allowed cycle still wins over the timeout
        if (bus.mem_ready) begin
          if (ctrl_q.memRead) begin
            state_d = S_WB;
          end else begin
            pcEn    = 1'b1;
            ctrl_d  = '0;
            state_d = S_IF;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          ctrl_d    = '0;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        pcEn    = 1'b1;
        ctrl_d  = '0;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        ctrl_d  = '0;
        state_d = S_IF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      ctrl_q    <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.RegWrite     = (state_q == S_WB);
  assign bus.MemRead      = ctrl_q.memRead  & (state_q == S_MEM);
  assign bus.MemWrite     = ctrl_q.memWrite & (state_q == S_MEM);
  assign bus.ir_en        = (state_q == S_IF);
  assign bus.pc_en        = pcEn;
  assign bus.ImmSel       = ctrl_q.immSel;
  assign bus.ALUSrc       = ctrl_q.aluSrc;
  assign bus.CompEnbl     = ctrl_q.compEnbl;
  assign bus.ShiftAmntSel = ctrl_q.shiftAmntSel;
  assign bus.ShiftEnbl    = ctrl_q.shiftEnbl;
  assign bus.ShortBr      = ctrl_q.shortBr;
  assign bus.LongBr       = ctrl_q.longBr;
  assign bus.BranchReg    = ctrl_q.branchReg;
  assign bus.ALUOp        = ctrl_q.aluOp;
  assign bus.RegDst       = ctrl_q.regDst;
  assign bus.ShiftType    = ctrl_q.shiftType;
  assign bus.BranchType   = ctrl_q.branchType;
  assign bus.JumpType     = ctrl_q.jumpType;
  assign bus.MemToReg     = ctrl_q.memToReg;
  assign bus.state        = state_q;
  assign bus.illegal      = illegal_q;
  assign bus.mem_err      = mem_err_q;
  assign bus.halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_minirisc_control_sequencer.sv
// Directed bench for the miniRISC control sequencer: per-cycle strobe, bundle
// and flag expectations for each instruction class, worked out by hand.
module tb_minirisc_control_sequencer;

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  typedef struct packed {
    logic       ImmSel;
    logic       ALUSrc;
    logic       CompEnbl;
    logic       ShiftAmntSel;
    logic       ShiftEnbl;
    logic       ShortBr;
    logic       LongBr;
    logic       BranchReg;
    logic [1:0] ALUOp;
    logic [1:0] RegDst;
    logic [1:0] ShiftType;
    logic [1:0] BranchType;
    logic [1:0] JumpType;
    logic [1:0] MemToReg;
  } bundle_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  minirisc_ctrl_if bus();

  minirisc_control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe vector: {state, ir_en, pc_en, RegWrite, MemRead, MemWrite}
  function automatic logic [7:0] strobeObs();
    return {bus.state, bus.ir_en, bus.pc_en, bus.RegWrite, bus.MemRead, bus.MemWrite};
  endfunction

  function automatic bundle_t bundleObs();
    bundle_t b;
    b.ImmSel       = bus.ImmSel;
    b.ALUSrc       = bus.ALUSrc;
    b.CompEnbl     = bus.CompEnbl;
    b.ShiftAmntSel = bus.ShiftAmntSel;
    b.ShiftEnbl    = bus.ShiftEnbl;
    b.ShortBr      = bus.ShortBr;
    b.LongBr       = bus.LongBr;
    b.BranchReg    = bus.BranchReg;
    b.ALUOp        = bus.ALUOp;
    b.RegDst       = bus.RegDst;
    b.ShiftType    = bus.ShiftType;
    b.BranchType   = bus.BranchType;
    b.JumpType     = bus.JumpType;
    b.MemToReg     = bus.MemToReg;
    return b;
  endfunction

  // Flags: {illegal, mem_err, halted}
  function automatic logic [2:0] flagObs();
    return {bus.illegal, bus.mem_err, bus.halted};
  endfunction

  // Leaves the bench 1ns into the first IF cycle after reset
  task automatic doReset(input logic [5:0] op, input logic [4:0] fn);
    @(negedge clk);
    rst           = 1'b1;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic ready);
    @(negedge clk);
    bus.mem_ready = ready;
    #1;
  endtask

  task automatic test_reset();
    doReset(6'b000001, 5'd0);
    checks++;
    if (strobeObs() !== {ST_IF, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %h expected %h", strobeObs(), {ST_IF, 5'b10000});
    end
    checks++;
    if (bundleObs() !== bundle_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_bundle got %h expected 0", bundleObs());
    end
    checks++;
    if (flagObs() !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 000", flagObs());
    end
  endtask

  task automatic test_addi();
    logic [7:0] expS;
    bundle_t    expB;
    bundle_t    addiB;
    addiB        = '0;
    addiB.ALUSrc = 1'b1;
    addiB.ALUOp  = 2'b01;
    doReset(6'b000001, 5'd0);
    for (int c = 0; c <= 4; c++) begin
      expB = '0;
      case (c)
        0:       expS = {ST_IF, 5'b10000};
        1:       expS = {ST_ID, 5'b00000};
        2:       begin expS = {ST_EX, 5'b00000}; expB = addiB; end
        3:       begin expS = {ST_WB, 5'b01100}; expB = addiB; end
        default: expS = {ST_IF, 5'b10000};
      endcase
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL addi_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL addi_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      if (c < 4) applyStimulus(1'b0);
    end
  endtask

  task automatic test_lw_wait();
    logic [7:0] expS;
    bundle_t    expB;
    bundle_t    lwB;
    lwB          = '0;
    lwB.ALUSrc   = 1'b1;
    lwB.ImmSel   = 1'b1;
    lwB.ALUOp    = 2'b01;
    lwB.MemToReg = 2'b01;
    doReset(6'b000011, 5'd0);
    for (int c = 0; c <= 8; c++) begin
      expB = '0;
      case (c)
        0:             expS = {ST_IF, 5'b10000};
        1:             expS = {ST_ID, 5'b00000};
        2:             begin expS = {ST_EX, 5'b00000}; expB = lwB; end
        3, 4, 5, 6:    begin expS = {ST_MEM, 5'b00010}; expB = lwB; end
        7:             begin expS = {ST_WB, 5'b01100}; expB = lwB; end
        default:       expS = {ST_IF, 5'b10000};
      endcase
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL lw_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL lw_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      if (c < 8) applyStimulus((c + 1) == 6);
    end
  endtask

  task automatic test_sw_timeout();
    logic [7:0] expS;
    logic [2:0] expF;
    bundle_t    expB;
    bundle_t    swB;
    swB          = '0;
    swB.ALUSrc   = 1'b1;
    swB.ImmSel   = 1'b1;
    swB.ALUOp    = 2'b01;
    doReset(6'b000100, 5'd0);
    for (int c = 0; c <= 21; c++) begin
      expB = '0;
      expF = 3'b000;
      if (c == 0) expS = {ST_IF, 5'b10000};
      else if (c == 1) expS = {ST_ID, 5'b00000};
      else if (c == 2) begin expS = {ST_EX, 5'b00000}; expB = swB; end
      else if (c <= 17) begin expS = {ST_MEM, 5'b00001}; expB = swB; end
      else begin expS = {ST_HALT, 5'b00000}; expF = 3'b011; end
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL sw_timeout_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL sw_timeout_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      checks++;
      if (flagObs() !== expF) begin
        errors++;
        $display("[TB] FAIL sw_timeout_flags cycle %0d got %b expected %b", c, flagObs(), expF);
      end
      if (c < 21) applyStimulus(1'b0);
    end
    doReset(6'b000001, 5'd0);
    checks++;
    if ({strobeObs(), flagObs()} !== {ST_IF, 5'b10000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL sw_timeout_rst_clear got %h/%b expected %h/000", strobeObs(), flagObs(), {ST_IF, 5'b10000});
    end
  endtask

  task automatic test_mem_boundary();
    logic [7:0] expS;
    doReset(6'b000100, 5'd0);
    for (int c = 0; c <= 18; c++) begin
      if (c == 0 || c == 18) expS = {ST_IF, 5'b10000};
      else if (c == 1) expS = {ST_ID, 5'b00000};
      else if (c == 2) expS = {ST_EX, 5'b00000};
      else if (c < 17) expS = {ST_MEM, 5'b00001};
      else expS = {ST_MEM, 5'b01001};
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL mem_boundary_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      if (c == 18) begin
        checks++;
        if (flagObs() !== 3'b000) begin
          errors++;
          $display("[TB] FAIL mem_boundary_flags got %b expected 000", flagObs());
        end
      end
      if (c < 18) applyStimulus((c + 1) == 17);
    end
  endtask

  task automatic test_branches();
    logic [7:0] expS;
    bundle_t    expB;
    bundle_t    blB;
    bundle_t    bzB;
    blB            = '0;
    blB.LongBr     = 1'b1;
    blB.JumpType   = 2'b01;
    blB.RegDst     = 2'b10;
    blB.MemToReg   = 2'b10;
    bzB            = '0;
    bzB.ShortBr    = 1'b1;
    bzB.BranchType = 2'b01;
    doReset(6'b001101, 5'd0);
    for (int c = 0; c <= 7; c++) begin
      expB = '0;
      case (c)
        0, 4:    expS = {ST_IF, 5'b10000};
        1, 5:    expS = {ST_ID, 5'b00000};
        2:       begin expS = {ST_EX, 5'b00000}; expB = blB; end
        3:       begin expS = {ST_WB, 5'b01100}; expB = blB; end
        6:       begin expS = {ST_EX, 5'b01000}; expB = bzB; end
        default: expS = {ST_IF, 5'b10000};
      endcase
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL branch_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL branch_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      if (c < 7) applyStimulus(1'b0);
      if (c + 1 == 4) bus.opcode = 6'b001001;
    end
  endtask

  task automatic test_illegal();
    logic [7:0] expS;
    logic [2:0] expF;
    bundle_t    expB;
    bundle_t    xorB;
    xorB       = '0;
    xorB.ALUOp = 2'b11;
    doReset(6'b010101, 5'd0);
    for (int c = 0; c <= 8; c++) begin
      expB = '0;
      expF = (c >= 2) ? 3'b100 : 3'b000;
      case (c)
        0, 2, 4, 8: expS = {ST_IF, 5'b10000};
        1, 3:       expS = {ST_ID, 5'b01000};
        5:          expS = {ST_ID, 5'b00000};
        6:          begin expS = {ST_EX, 5'b00000}; expB = xorB; end
        default:    begin expS = {ST_WB, 5'b01100}; expB = xorB; end
      endcase
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL illegal_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL illegal_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      checks++;
      if (flagObs() !== expF) begin
        errors++;
        $display("[TB] FAIL illegal_flags cycle %0d got %b expected %b", c, flagObs(), expF);
      end
      if (c < 8) applyStimulus(1'b0);
      if (c + 1 == 2) begin bus.opcode = 6'b000000; bus.funct = 5'd12; end
      if (c + 1 == 4) bus.funct = 5'd3;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expS;
    bundle_t    expB;
    bundle_t    shravB;
    bundle_t    compB;
    bundle_t    andB;
    shravB              = '0;
    shravB.ShiftEnbl    = 1'b1;
    shravB.ShiftType    = 2'b10;
    shravB.ShiftAmntSel = 1'b1;
    compB               = '0;
    compB.ALUOp         = 2'b01;
    compB.CompEnbl      = 1'b1;
    andB                = '0;
    andB.ALUOp          = 2'b10;
    doReset(6'b000000, 5'd9);
    for (int c = 0; c <= 12; c++) begin
      expB = '0;
      case (c % 4)
        0:       expS = {ST_IF, 5'b10000};
        1:       expS = {ST_ID, 5'b00000};
        2:       expS = {ST_EX, 5'b00000};
        default: expS = {ST_WB, 5'b01100};
      endcase
      if (c == 2 || c == 3) expB = shravB;
      if (c == 6 || c == 7) expB = compB;
      if (c == 10 || c == 11) expB = andB;
      checks++;
      if (strobeObs() !== expS) begin
        errors++;
        $display("[TB] FAIL b2b_strobes cycle %0d got %h expected %h", c, strobeObs(), expS);
      end
      checks++;
      if (bundleObs() !== expB) begin
        errors++;
        $display("[TB] FAIL b2b_bundle cycle %0d got %h expected %h", c, bundleObs(), expB);
      end
      if (c < 12) applyStimulus(1'b0);
      if (c + 1 == 4) bus.funct = 5'd1;
      if (c + 1 == 8) bus.funct = 5'd2;
    end
  endtask

  task automatic test_reset_mid();
    doReset(6'b000011, 5'd0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0);
    checks++;
    if (strobeObs() !== {ST_MEM, 5'b00010}) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre got %h expected %h", strobeObs(), {ST_MEM, 5'b00010});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (strobeObs() !== {ST_IF, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_strobes got %h expected %h", strobeObs(), {ST_IF, 5'b10000});
    end
    checks++;
    if ({bundleObs(), flagObs()} !== {bundle_t'(0), 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_bundle got %h/%b expected 0/000", bundleObs(), flagObs());
    end
    applyStimulus(1'b0);
    checks++;
    if (strobeObs() !== {ST_ID, 5'b00000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_next got %h expected %h", strobeObs(), {ST_ID, 5'b00000});
    end
  endtask

  task automatic test_halt();
    logic [7:0] expS;
    logic [2:0] expF;
    doReset(6'b111111, 5'd0);
    for (int c = 0; c <= 21; c++) begin
      expF = 3'b000;
      if (c == 0) expS = {ST_IF, 5'b10000};
      else if (c == 1) expS = {ST_ID, 5'b00000};
      else begin expS = {ST_HALT, 5'b00000}; expF = 3'b001; end
      checks++;
      if ({strobeObs(), flagObs()} !== {expS, expF}) begin
        errors++;
        $display("[TB] FAIL halt cycle %0d got %h/%b expected %h/%b", c, strobeObs(), flagObs(), expS, expF);
      end
      if (c < 21) applyStimulus(1'b0);
    end
    doReset(6'b000001, 5'd0);
    checks++;
    if ({strobeObs(), flagObs()} !== {ST_IF, 5'b10000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL halt_rst_exit got %h/%b expected %h/000", strobeObs(), flagObs(), {ST_IF, 5'b10000});
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.opcode    = 6'b000000;
    bus.funct     = 5'd0;
    bus.mem_ready = 1'b0;
    $display("[TB] starting miniRISC control sequencer bench");
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_timeout();
    test_mem_boundary();
    test_branches();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minirisc_control_sequencer.md
Name: miniRISC_control_sequencer

Overview:
- Multi-cycle control FSM for the KGP miniRISC datapath (CPU_TOP_MODULE).
- Replaces hand-driven control vectors: takes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the full control bundle plus PC/IR load strobes.
- Handles data-memory wait handshake, halt and illegal opcodes.

Parameters:
- MEM_WAIT_MAX, 15, max cycles waiting for mem_ready in MEM before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26], sampled in ID.
- funct  in  5  IR[4:0], sampled in ID.
- mem_ready  in  1  data memory completes access this cycle.
- RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg  out  1 each  datapath controls.
- ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg  out  2 each  datapath controls.
- ir_en  out  1  load IR.
- pc_en  out  1  update PC (next-PC mux chosen by the bundle).
- state  out  3  current FSM state.
- illegal  out  1  sticky; undefined opcode/funct seen.
- mem_err  out  1  sticky; mem_ready timeout.
- halted  out  1  FSM in HALT.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Reset: state=IF; all outputs 0, including sticky flags and wait counter. Reset mid-instruction aborts it with no strobe issued.
- Decode table, latched on ID->EX and held until the instruction retires. Unlisted bundle fields are 0.
  - 000000 R-type: ALUSrc=0.
    - funct 0 add: ALUOp=01.
    - funct 1 comp: ALUOp=01, CompEnbl=1.
    - funct 2 and: ALUOp=10.
    - funct 3 xor: ALUOp=11.
    - funct 4..9 (shll, shrl, shllv, shrlv, shra, shrav): ShiftEnbl=1; ShiftType 00/01/10 for ll/rl/ra; ShiftAmntSel=1 for the v forms.
    - Any other funct is illegal.
  - 000001 addi: ALUSrc=1, ALUOp=01.
  - 000010 compi: addi fields plus CompEnbl=1.
  - 000011 lw: ALUSrc=1, ImmSel=1, ALUOp=01, MemRead, MemToReg=01.
  - 000100 sw: ALUSrc=1, ImmSel=1, ALUOp=01, MemWrite.
  - 000101 br: BranchReg=1.
  - 0010tt short branch (tt≠11): ShortBr=1, BranchType=tt.
  - 0011jj long: LongBr=1, JumpType=jj. jj=01 (bl) adds RegDst=10, MemToReg=10.
  - 111111 halt.
  - Anything else is illegal.
- Transitions and strobes:
  - IF: ir_en=1 for one cycle; next ID.
  - ID: next EX; halt -> HALT; illegal -> set illegal, pc_en=1, next IF (treated as nop).
  - EX: ALU, shift and bl -> WB. lw/sw -> MEM. Other branches -> pc_en=1, next IF.
  - MEM: MemRead/MemWrite held high. Wait counter increments each cycle without mem_ready.
    - mem_ready: lw -> WB; sw -> pc_en=1, next IF.
    - Counter reaches MEM_WAIT_MAX without mem_ready: mem_err=1, strobes drop, next HALT.
    - mem_ready in the same cycle the limit is reached counts as success.
  - WB: RegWrite=1 for exactly one cycle, pc_en=1, next IF.
- Strobes (RegWrite, MemRead, MemWrite, pc_en, ir_en) are 0 in every state not listed above.
- Bundle is all-zero in IF and HALT.
- Latency in cycles: ALU/bl 4, branch 3, sw 4+w, lw 5+w, where w is the number of MEM cycles without mem_ready.
- HALT: absorbing; only rst exits. halted=1.
- All outputs registered or decoded from registered state; no combinational path from mem_ready to any output except the MEM exit decision.

Test Plan:
- addi (000001) after reset: ir_en at cycle 0; RegWrite=1 and pc_en=1 only in cycle 3; ALUSrc=1, ALUOp=01 throughout EX/WB; state back to IF at cycle 4.
- lw with mem_ready low 3 cycles: MemRead high 4 cycles in MEM, MemToReg=01, RegWrite pulse in the following WB; total 8 cycles.
- sw, mem_ready never asserted, MEM_WAIT_MAX=15: mem_err=1 after 15 MEM cycles, MemWrite drops, halted=1, no pc_en. Later rst clears all flags, state=IF.
- bl (001101): LongBr=1, JumpType=01, RegDst=10, MemToReg=10, single RegWrite in WB. bz (001001): ShortBr=1, BranchType=01, pc_en in EX, no RegWrite.
- opcode 010101 and R-type funct 12: illegal set and stays 1, pc_en pulse in ID, no RegWrite/MemWrite. Next instruction executes normally.
- rst asserted in MEM of an lw with mem_ready low: next cycle state=IF, all outputs 0, no RegWrite. Halt opcode: halted=1, ir_en stays 0 for 20 cycles.
